// File: rtl/fir_stream_feeder_if.sv
// fir_stream_feeder_if: upstream, core and downstream handshake signals of the FIR stream feeder.
// slave is the feeder's view, master the environment's view.
interface fir_stream_feeder_if #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_data;
  logic [IN_WIDTH-1:0]  fir_data;
  logic                 fir_valid;
  logic [ACC_WIDTH-1:0] fir_out;
  logic                 fir_out_valid;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  modport slave (
    input  s_valid, s_data, fir_out, fir_out_valid, m_ready,
    output s_ready, fir_data, fir_valid, m_valid, m_data
  );
  modport master (
    output s_valid, s_data, fir_out, fir_out_valid, m_ready,
    input  s_ready, fir_data, fir_valid, m_valid, m_data
  );
endinterface

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: FIFO-buffered, one-at-a-time feeder for the FIR core with rounding/saturation and timeout.
// Define FIR_FEEDER_STATS_EN to add the stat_done/stat_sat counters.
module fir_stream_feeder #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_stream_feeder_if.slave bus,
  input  logic               err_clr,
  output logic               err_timeout
`ifdef FIR_FEEDER_STATS_EN
  ,
  output logic [31:0]        stat_done,
  output logic [15:0]        stat_sat
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  typedef enum logic {IDLE, WAIT} state_t;
  state_t st_q, st_d;
  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic s_ready_q, fir_valid_q, m_valid_q, err_q;
  logic [IN_WIDTH-1:0] fir_data_q;
  logic [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic push, pop, got, tout;
  logic signed [ACC_WIDTH:0] rnd, r;
  assign push = bus.s_valid && s_ready_q;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  // Holding issue while a result waits downstream keeps at most one result outstanding.
  always_comb begin
    st_d = st_q;
    tmr_d = tmr_q;
    pop = 1'b0;
    got = 1'b0;
    tout = 1'b0;
    if (st_q == IDLE) begin
      if (cnt_q != '0 && !m_valid_q) begin
        pop = 1'b1;
        tmr_d = '0;
        st_d = WAIT;
      end
    end else begin
      tmr_d = tmr_q + TW'(1);
      if (bus.fir_out_valid) begin
        got = 1'b1;
        st_d = IDLE;
      end else if (tmr_q == TW'(TIMEOUT - 1)) begin
        tout = 1'b1;
        st_d = IDLE;
      end
    end
  end
  always_comb begin
    rnd = $signed({bus.fir_out[ACC_WIDTH-1], bus.fir_out}) + HALF;
    r = rnd >>> SHIFT;
    m_data_d = r > MAXV ? MAXV[OUT_WIDTH-1:0] : r < MINV ? MINV[OUT_WIDTH-1:0] : r[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk)
    if (push) mem[wptr_q] <= bus.s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      tmr_q <= '0;
      s_ready_q <= 1'b1;
      fir_valid_q <= 1'b0;
      fir_data_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      tmr_q <= tmr_d;
      s_ready_q <= cnt_d != CW'(DEPTH);
      fir_valid_q <= pop;
      if (pop) fir_data_q <= mem[rptr_q];
      if (got) begin
        m_valid_q <= 1'b1;
        m_data_q <= m_data_d;
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      err_q <= !err_clr && (err_q || tout);
    end
`ifdef FIR_FEEDER_STATS_EN
  logic sat;
  assign sat = (r > MAXV) || (r < MINV);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_done <= '0;
      stat_sat <= '0;
    end else begin
      stat_done <= stat_done + 32'(m_valid_q && bus.m_ready);
      stat_sat <= stat_sat + 16'(got && sat);
    end
`endif
  assign bus.s_ready = s_ready_q;
  assign bus.fir_data = fir_data_q;
  assign bus.fir_valid = fir_valid_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data = m_data_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_fir_stream_feeder.sv
// tb_fir_stream_feeder: directed bench for fir_stream_feeder with a hand-driven core model.
module tb_fir_stream_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic err_timeout;
  int errs = 0;
  int checks = 0;
  logic [39:0] vres [5] = '{40'h7FFFFFFFFF, 40'h8000000000, 40'd16384, 40'hFFFFFFC000, 40'hFFFFFFBFFF};
  int vexp [5] = '{32767, -32768, 1, 0, -1};
`ifdef FIR_FEEDER_STATS_EN
  logic [31:0] stat_done;
  logic [15:0] stat_sat;
`endif
  always #5 clk = ~clk;
  fir_stream_feeder_if bus();
  fir_stream_feeder dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_clr(err_clr),
    .err_timeout(err_timeout)
`ifdef FIR_FEEDER_STATS_EN
    ,
    .stat_done(stat_done),
    .stat_sat(stat_sat)
`endif
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [15:0] d);
    bus.s_valid = 1'b1;
    bus.s_data = d;
    tick();
    bus.s_valid = 1'b0;
  endtask
  task automatic wait_fir();
    int n;
    n = 0;
    while (!bus.fir_valid && n < 50) begin
      tick();
      n++;
    end
    if (!bus.fir_valid) chk("fir_valid_wait", 0, 1);
  endtask
  task automatic respond(input logic [39:0] res);
    bus.fir_out = res;
    bus.fir_out_valid = 1'b1;
    tick();
    bus.fir_out_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    int pulses, acc;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.fir_out = '0;
    bus.fir_out_valid = 1'b0;
    bus.m_ready = 1'b0;
    do_reset();
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_fir_valid", bus.fir_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_m_data", bus.m_data, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.fir_valid);
    end
    chk("rst_fifo_empty", pulses, 0);
    // single sample through a 360-cycle core
    push1(16'd100);
    wait_fir();
    chk("t2_fir_data", bus.fir_data, 100);
    pulses = 1;
    for (int i = 0; i < 359; i++) begin
      tick();
      pulses += int'(bus.fir_valid);
    end
    chk("t2_pulses", pulses, 1);
    chk("t2_m_valid_before", bus.m_valid, 0);
    respond(40'd3276800);
    chk("t2_m_valid", bus.m_valid, 1);
    chk("t2_m_data", $signed(bus.m_data), 100);
    tick();
    chk("t2_m_held", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("t2_m_cleared", bus.m_valid, 0);
    // rounding and saturation vectors
    for (int i = 0; i < 5; i++) begin
      push1(16'(i));
      wait_fir();
      respond(vres[i]);
      chk($sformatf("t3_m_data_%0d", i), $signed(bus.m_data), vexp[i]);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
    end
    // backpressure fill
    acc = 0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.s_data = 16'(i + 1);
      acc += int'(bus.s_ready);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("t4_accepted", acc, 9);
    chk("t4_s_ready", bus.s_ready, 0);
    respond(40'd0);
    chk("t4_m_valid", bus.m_valid, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(bus.fir_valid);
    end
    chk("t4_no_issue", pulses, 0);
    chk("t4_s_ready_held", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    tick();
    chk("t4_m_cleared", bus.m_valid, 0);
    tick();
    chk("t4_next_issue", bus.fir_valid, 1);
    chk("t4_next_data", bus.fir_data, 2);
    respond(40'd0);
    for (int i = 0; i < 7; i++) begin
      wait_fir();
      chk($sformatf("t4_drain_%0d", i), bus.fir_data, i + 3);
      respond(40'd0);
    end
    tick();
    tick();
    chk("t4_drained_ready", bus.s_ready, 1);
    chk("t4_drained_m_valid", bus.m_valid, 0);
    // core never answers
    push1(16'd7);
    push1(16'd8);
    wait_fir();
    chk("t5_fir_data", bus.fir_data, 7);
    for (int i = 0; i < 1023; i++) tick();
    chk("t5_err_early", err_timeout, 0);
    tick();
    chk("t5_err_set", err_timeout, 1);
    tick();
    chk("t5_next_issue", bus.fir_valid, 1);
    chk("t5_next_data", bus.fir_data, 8);
    respond(40'd0);
    chk("t5_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", err_timeout, 0);
    tick();
    bus.m_ready = 1'b0;
    do_reset();
`ifdef FIR_FEEDER_STATS_EN
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push1(16'(i));
      wait_fir();
      respond(vres[i]);
      tick();
    end
    chk("t6_stat_done", stat_done, 5);
    chk("t6_stat_sat", stat_sat, 2);
    bus.m_ready = 1'b0;
`endif
    // reset in the middle of a WAIT with a sample still queued
    push1(16'd5);
    push1(16'd6);
    wait_fir();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fir_valid", bus.fir_valid, 0);
    chk("t6_rst_s_ready", bus.s_ready, 1);
    chk("t6_rst_fir_data", bus.fir_data, 0);
`ifdef FIR_FEEDER_STATS_EN
    chk("t6_rst_stat_done", stat_done, 0);
    chk("t6_rst_stat_sat", stat_sat, 0);
`endif
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(bus.fir_valid);
    end
    chk("t6_fifo_discarded", pulses, 0);
    respond(40'd3276800);
    chk("t6_spurious_ignored", bus.m_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
